// File: rtl/boa_stage_id.sv
// boa_stage_id: RV32I decode stage with static branch prediction and ID/EX register.
// Define BOA_RV32M_EN to accept the RV32M funct7=0000001 OP group as legal.
module boa_stage_id (
   input  logic        clk,
   input  logic        rst,
   input  logic        d_valid,
   input  logic [31:1] d_pc,
   input  logic [31:0] d_insn,
   input  logic        d_trap,
   input  logic [3:0]  d_cause,
   output logic        if_branch_predict,
   output logic [31:1] if_branch_target,
   input  logic        fw_stall_id,
   input  logic        fw_stall_ex,
   input  logic        fw_branch_correct,
   output logic        q_valid,
   output logic [31:1] q_pc,
   output logic [31:0] q_insn,
   output logic        q_trap,
   output logic [3:0]  q_cause,
   output logic [4:0]  q_rs1,
   output logic [4:0]  q_rs2,
   output logic [4:0]  q_rd,
   output logic        q_use_rs1,
   output logic        q_use_rs2,
   output logic [31:0] q_imm,
   output logic        q_branch_predict
);
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   logic        w_m_en;
`ifdef BOA_RV32M_EN
   assign w_m_en = 1'b1;
`else
   assign w_m_en = 1'b0;
`endif

   logic [6:0]  w_opc, w_f7;
   logic [2:0]  w_f3;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
   logic        w_legal, w_u1, w_u2, w_urd;
   logic        w_ill, w_ecall, w_ebreak, w_trap, w_cand;
   logic [3:0]  w_cause;

   assign w_opc   = d_insn[6:0];
   assign w_f3    = d_insn[14:12];
   assign w_f7    = d_insn[31:25];
   assign w_imm_i = {{20{d_insn[31]}}, d_insn[31:20]};
   assign w_imm_s = {{20{d_insn[31]}}, d_insn[31:25], d_insn[11:7]};
   assign w_imm_b = {{19{d_insn[31]}}, d_insn[31], d_insn[7], d_insn[30:25], d_insn[11:8], 1'b0};
   assign w_imm_u = {d_insn[31:12], 12'b0};
   assign w_imm_j = {{11{d_insn[31]}}, d_insn[31], d_insn[19:12], d_insn[20], d_insn[30:21], 1'b0};

   always_comb begin
      w_legal = 1'b0;
      w_u1    = 1'b0;
      w_u2    = 1'b0;
      w_urd   = 1'b0;
      w_imm   = '0;
      case (w_opc)
         OPC_LUI, OPC_AUIPC: begin w_legal = 1'b1; w_urd = 1'b1; w_imm = w_imm_u; end
         OPC_JAL:    begin w_legal = 1'b1; w_urd = 1'b1; w_imm = w_imm_j; end
         OPC_JALR:   begin w_legal = 1'b1; w_u1 = 1'b1; w_urd = 1'b1; w_imm = w_imm_i; end
         OPC_BRANCH: begin w_legal = w_f3[2:1] != 2'b01; w_u1 = 1'b1; w_u2 = 1'b1; w_imm = w_imm_b; end
         OPC_LOAD:   begin w_legal = w_f3 != 3'd3 && w_f3 < 3'd6; w_u1 = 1'b1; w_urd = 1'b1; w_imm = w_imm_i; end
         OPC_STORE:  begin w_legal = w_f3 < 3'd3; w_u1 = 1'b1; w_u2 = 1'b1; w_imm = w_imm_s; end
         OPC_OPIMM: begin
            w_legal = w_f3 == 3'b001 ? w_f7 == 7'b0 :
                      w_f3 == 3'b101 ? (w_f7 == 7'b0 || w_f7 == 7'b0100000) : 1'b1;
            w_u1    = 1'b1;
            w_urd   = 1'b1;
            w_imm   = w_imm_i;
         end
         OPC_OP: begin
            w_legal = w_f7 == 7'b0 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) ||
                      (w_f7 == 7'b0000001 && w_m_en);
            w_u1    = 1'b1;
            w_u2    = 1'b1;
            w_urd   = 1'b1;
         end
         OPC_FENCE:  begin w_legal = 1'b1; w_imm = w_imm_i; end
         // CSR forms: funct3 001..011 read rs1, 101..111 take a zimm; all write rd
         OPC_SYSTEM: begin
            w_legal = 1'b1;
            w_u1    = w_f3 != 3'b000 && !w_f3[2];
            w_urd   = w_f3[1:0] != 2'b00;
            w_imm   = w_imm_i;
         end
         default: ;
      endcase
   end

   assign w_ill    = !w_legal || d_insn == 32'h0 || &d_insn;
   assign w_ecall  = d_insn == 32'h0000_0073;
   assign w_ebreak = d_insn == 32'h0010_0073;
   assign w_trap   = d_trap || w_ill || w_ecall || w_ebreak;
   assign w_cause  = d_trap ? d_cause : w_ill ? 4'd2 : w_ecall ? 4'd11 : w_ebreak ? 4'd3 : 4'd0;
   assign w_cand   = w_opc == OPC_JAL || (w_opc == OPC_BRANCH && d_insn[31]);

   assign if_branch_predict = w_cand && d_valid && !w_trap && !fw_stall_id && !fw_stall_ex &&
                              !fw_branch_correct && !rst;
   assign if_branch_target  = d_pc + w_imm[31:1];

   logic        r_valid, r_trap, r_use1, r_use2, r_bp;
   logic [31:1] r_pc;
   logic [31:0] r_insn, r_imm;
   logic [3:0]  r_cause;
   logic [4:0]  r_rs1, r_rs2, r_rd;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_trap  <= 1'b0;
         r_cause <= '0;
         r_bp    <= 1'b0;
         r_pc    <= '0;
         r_insn  <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_rd    <= '0;
         r_use1  <= 1'b0;
         r_use2  <= 1'b0;
         r_imm   <= '0;
      end else if (fw_branch_correct) begin
         r_valid <= 1'b0;
         r_bp    <= 1'b0;
      end else if (!fw_stall_ex) begin
         r_valid <= d_valid && !fw_stall_id;
         r_trap  <= w_trap;
         r_cause <= w_cause;
         r_bp    <= if_branch_predict;
         r_pc    <= d_pc;
         r_insn  <= d_insn;
         r_rs1   <= (w_u1 && !w_trap) ? d_insn[19:15] : 5'd0;
         r_rs2   <= (w_u2 && !w_trap) ? d_insn[24:20] : 5'd0;
         r_rd    <= (w_urd && !w_trap) ? d_insn[11:7] : 5'd0;
         r_use1  <= w_u1 && !w_trap;
         r_use2  <= w_u2 && !w_trap;
         r_imm   <= w_imm;
      end
   end

   assign q_valid          = r_valid;
   assign q_pc             = r_pc;
   assign q_insn           = r_insn;
   assign q_trap           = r_trap;
   assign q_cause          = r_cause;
   assign q_rs1            = r_rs1;
   assign q_rs2            = r_rs2;
   assign q_rd             = r_rd;
   assign q_use_rs1        = r_use1;
   assign q_use_rs2        = r_use2;
   assign q_imm            = r_imm;
   assign q_branch_predict = r_bp;
endmodule

// File: tb/tb_boa_stage_id.sv
// tb_boa_stage_id: directed vectors for boa_stage_id with a queue-based scoreboard.
module tb_boa_stage_id;
   logic        clk = 1'b0, rst = 1'b1;
   logic        d_valid = 1'b0, d_trap = 1'b0;
   logic [31:1] d_pc = '0;
   logic [31:0] d_insn = 32'h13;
   logic [3:0]  d_cause = '0;
   logic        fw_stall_id = 1'b0, fw_stall_ex = 1'b0, fw_branch_correct = 1'b0;
   logic        if_branch_predict, q_valid, q_trap, q_use_rs1, q_use_rs2, q_branch_predict;
   logic [31:1] if_branch_target, q_pc;
   logic [31:0] q_insn, q_imm;
   logic [3:0]  q_cause;
   logic [4:0]  q_rs1, q_rs2, q_rd;

   boa_stage_id dut (
      .clk(clk), .rst(rst), .d_valid(d_valid), .d_pc(d_pc), .d_insn(d_insn), .d_trap(d_trap),
      .d_cause(d_cause), .if_branch_predict(if_branch_predict), .if_branch_target(if_branch_target),
      .fw_stall_id(fw_stall_id), .fw_stall_ex(fw_stall_ex), .fw_branch_correct(fw_branch_correct),
      .q_valid(q_valid), .q_pc(q_pc), .q_insn(q_insn), .q_trap(q_trap), .q_cause(q_cause),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .q_use_rs1(q_use_rs1), .q_use_rs2(q_use_rs2),
      .q_imm(q_imm), .q_branch_predict(q_branch_predict)
   );

   always #5 clk = ~clk;

   // full=0: only valid/branch_predict are defined; ci=0: immediate is don't-care
   typedef struct packed {
      logic        full;
      logic        valid;
      logic        trap;
      logic [3:0]  cause;
      logic [4:0]  rs1, rs2, rd;
      logic        u1, u2, ci;
      logic [31:0] imm;
      logic        bp;
      logic [30:0] pc;
      logic [31:0] insn;
   } exp_t;

   exp_t sbq[$];
   exp_t last;
   int   n_chk = 0, n_fail = 0;

   localparam logic [31:0] NOP = 32'h0000_0013, JAL = 32'h0100_006F, BEQ_B = 32'hFE20_8CE3;
   localparam logic [31:0] BEQ_F = 32'h0020_8463, ONES = 32'hFFFF_FFFF, LW = 32'h0043_2283;
   localparam logic [31:0] SW = 32'h0020_A423, ECALL = 32'h0000_0073, EBREAK = 32'h0010_0073;
   localparam logic [31:0] MUL = 32'h0220_8033, LUI = 32'h1234_51B7, CSRRW = 32'h3003_12F3;
   localparam logic [31:0] SUB = 32'h4031_00B3, BADSUB = 32'h4031_10B3;

   function automatic exp_t mk(input logic v, tr, input logic [3:0] ca, input logic [4:0] r1, r2, rd,
                               input logic u1, u2, ci, input logic [31:0] imm, input logic bp,
                               input logic [30:0] pc, input logic [31:0] insn);
      mk = '{full: 1'b1, valid: v, trap: tr, cause: ca, rs1: r1, rs2: r2, rd: rd, u1: u1, u2: u2,
             ci: ci, imm: imm, bp: bp, pc: pc, insn: insn};
   endfunction

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   task automatic cyc(input logic r, v, input logic [30:0] pc, input logic [31:0] insn,
                      input logic tr, input logic [3:0] ca, input logic sid, sex, bc,
                      input exp_t e, input logic ep, input logic [30:0] et);
      @(negedge clk);
      rst = r; d_valid = v; d_pc = pc; d_insn = insn; d_trap = tr; d_cause = ca;
      fw_stall_id = sid; fw_stall_ex = sex; fw_branch_correct = bc;
      #1;
      chk("if_branch_predict", {31'b0, if_branch_predict}, {31'b0, ep});
      if (ep) chk("if_branch_target", {1'b0, if_branch_target}, {1'b0, et});
      sbq.push_back(e);
      last = e;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("q_valid", {31'b0, q_valid}, {31'b0, e.valid});
            chk("q_branch_predict", {31'b0, q_branch_predict}, {31'b0, e.bp});
            if (e.full) begin
               chk("q_trap", {31'b0, q_trap}, {31'b0, e.trap});
               chk("q_cause", {28'b0, q_cause}, {28'b0, e.cause});
               chk("q_rs1", {27'b0, q_rs1}, {27'b0, e.rs1});
               chk("q_rs2", {27'b0, q_rs2}, {27'b0, e.rs2});
               chk("q_rd", {27'b0, q_rd}, {27'b0, e.rd});
               chk("q_use_rs1", {31'b0, q_use_rs1}, {31'b0, e.u1});
               chk("q_use_rs2", {31'b0, q_use_rs2}, {31'b0, e.u2});
               chk("q_pc", {1'b0, q_pc}, {1'b0, e.pc});
               chk("q_insn", q_insn, e.insn);
               if (e.ci) chk("q_imm", q_imm, e.imm);
            end
         end
      end
   end

   initial begin : stim
      exp_t r0, e, mul_e;
      r0 = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
`ifdef BOA_RV32M_EN
      mul_e = mk(1, 0, 0, 1, 2, 0, 1, 1, 0, 0, 0, 31'h204, MUL);
`else
      mul_e = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 31'h204, MUL);
`endif
      cyc(1, 1, 0, NOP, 0, 0, 0, 0, 0, r0, 0, 0);
      cyc(1, 1, 31'h2000_0008, JAL, 0, 0, 0, 0, 0, r0, 0, 0);
      cyc(0, 1, 0, NOP, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, NOP), 0, 0);
      cyc(0, 1, 31'h2000_0008, JAL, 0, 0, 0, 0, 0,
          mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 16, 1, 31'h2000_0008, JAL), 1, 31'h2000_0010);
      cyc(0, 1, 31'h100, BEQ_B, 0, 0, 0, 0, 0,
          mk(1, 0, 0, 1, 2, 0, 1, 1, 1, 32'hFFFF_FFF8, 1, 31'h100, BEQ_B), 1, 31'h0FC);
      cyc(0, 1, 31'h104, BEQ_F, 0, 0, 0, 0, 0,
          mk(1, 0, 0, 1, 2, 0, 1, 1, 1, 8, 0, 31'h104, BEQ_F), 0, 0);
      cyc(0, 1, 31'h108, ONES, 0, 0, 0, 0, 0, mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 31'h108, ONES), 0, 0);
      cyc(0, 1, 31'h108, ONES, 1, 0, 0, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 31'h108, ONES), 0, 0);
      cyc(0, 1, 31'h10C, LW, 0, 0, 0, 0, 0, mk(1, 0, 0, 6, 0, 5, 1, 0, 1, 4, 0, 31'h10C, LW), 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 31'h2000_0008, JAL, 0, 0, 0, 1, 0, last, 0, 0);
      e = last; e.full = 0; e.valid = 0; e.bp = 0;
      cyc(0, 1, 31'h2000_0008, JAL, 0, 0, 1, 0, 0, e, 0, 0);
      cyc(0, 1, 31'h110, SW, 0, 0, 0, 0, 0, mk(1, 0, 0, 1, 2, 0, 1, 1, 1, 8, 0, 31'h110, SW), 0, 0);
      e = last; e.full = 0; e.valid = 0; e.bp = 0;
      cyc(0, 1, 31'h2000_0008, JAL, 0, 0, 0, 1, 1, e, 0, 0);
      cyc(0, 1, 31'h7FFF_FFFC, JAL, 0, 0, 0, 0, 0,
          mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 16, 1, 31'h7FFF_FFFC, JAL), 1, 31'h4);
      e = last; e.full = 0; e.valid = 0; e.bp = 0;
      cyc(0, 1, 0, NOP, 0, 0, 0, 0, 1, e, 0, 0);
      cyc(0, 1, 31'h200, ECALL, 0, 0, 0, 0, 0, mk(1, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 31'h200, ECALL), 0, 0);
      cyc(0, 1, 31'h202, EBREAK, 0, 0, 0, 0, 0, mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 31'h202, EBREAK), 0, 0);
      cyc(0, 1, 31'h204, MUL, 0, 0, 0, 0, 0, mul_e, 0, 0);
      cyc(0, 1, 31'h206, LUI, 0, 0, 0, 0, 0,
          mk(1, 0, 0, 0, 0, 3, 0, 0, 1, 32'h1234_5000, 0, 31'h206, LUI), 0, 0);
      cyc(0, 1, 31'h208, CSRRW, 0, 0, 0, 0, 0, mk(1, 0, 0, 6, 0, 5, 1, 0, 0, 0, 0, 31'h208, CSRRW), 0, 0);
      cyc(0, 1, 31'h20A, SUB, 0, 0, 0, 0, 0, mk(1, 0, 0, 2, 3, 1, 1, 1, 0, 0, 0, 31'h20A, SUB), 0, 0);
      cyc(0, 1, 31'h20C, BADSUB, 0, 0, 0, 0, 0, mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 31'h20C, BADSUB), 0, 0);
      cyc(0, 0, 31'h20E, NOP, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 31'h20E, NOP), 0, 0);
      cyc(0, 1, 31'h210, LW, 0, 0, 0, 0, 0, mk(1, 0, 0, 6, 0, 5, 1, 0, 1, 4, 0, 31'h210, LW), 0, 0);
      cyc(1, 1, 31'h212, JAL, 0, 0, 0, 1, 0, r0, 0, 0);
      cyc(0, 1, 31'h7FFF_FFFE, BEQ_B, 0, 0, 0, 0, 0,
          mk(1, 0, 0, 1, 2, 0, 1, 1, 1, 32'hFFFF_FFF8, 1, 31'h7FFF_FFFE, BEQ_B), 1, 31'h7FFF_FFFA);
      @(negedge clk);
      d_valid = 1'b0;
      @(posedge clk);
      #2;
      chk("scoreboard_drained", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
